// File: rtl/drift_injection_clock_generator_if.sv
// Control and observation bundle for the drift-injection clock generator.
// The master side sets the phase/drift controls and watches the generated clock;
// the slave side is the generator itself.
interface drift_injection_clock_generator_if #(
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned DRIFT_WIDTH   = 8
);
    logic                     gen_en_i;
    logic                     clear_state_i;
    logic [COUNTER_WIDTH-1:0] high_period_i;
    logic [COUNTER_WIDTH-1:0] low_period_i;
    logic [DRIFT_WIDTH-1:0]   drift_step_i;
    logic                     drift_dir_i;
    logic [COUNTER_WIDTH-1:0] drift_interval_i;
    logic [1:0]               drift_target_i;
    logic                     clk_o;
    logic                     rising_edge_o;
    logic                     falling_edge_o;
    logic                     any_valid_edge_o;
    logic                     drift_injected_o;

    modport master (
        output gen_en_i, clear_state_i, high_period_i, low_period_i,
               drift_step_i, drift_dir_i, drift_interval_i, drift_target_i,
        input  clk_o, rising_edge_o, falling_edge_o, any_valid_edge_o,
               drift_injected_o
    );

    modport slave (
        input  gen_en_i, clear_state_i, high_period_i, low_period_i,
               drift_step_i, drift_dir_i, drift_interval_i, drift_target_i,
        output clk_o, rising_edge_o, falling_edge_o, any_valid_edge_o,
               drift_injected_o
    );
endinterface

// File: rtl/drift_injection_clock_generator.sv
// Clock-domain bundle shared by blocks that take clk/rst_n as one port.
package common_p;
    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;
endpackage

// Synthesizes an IO clock from the system clock with programmable high/low
// half-periods and injects +/- drift into selected phases every Nth eligible edge.
module drift_injection_clock_generator #(
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned DRIFT_WIDTH   = 8
) (
    input  common_p::clk_dom_s                sys_dom_i,
    drift_injection_clock_generator_if.slave  bus
);

    localparam int unsigned CNT_W = COUNTER_WIDTH;
    localparam int unsigned DRF_W = DRIFT_WIDTH;
    // Drift arithmetic is one bit wider than the wider operand so saturation is visible.
    localparam int unsigned SUM_W = ((CNT_W > DRF_W) ? CNT_W : DRF_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    logic clk;
    logic rst_n;

    assign clk   = sys_dom_i.clk;
    assign rst_n = sys_dom_i.rst_n;

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  phase_cnt_q, phase_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              clk_q,      clk_d;
    logic              rise_q,     rise_d;
    logic              fall_q,     fall_d;
    logic              any_q,      any_d;
    logic              inj_q,      inj_d;

    logic              start_phase;
    logic              start_high;
    logic              eligible;
    logic              drift_now;
    logic              inject_enabled;
    logic [CNT_W-1:0]  eff_len;
    logic [CNT_W-1:0]  interval_m1;

    // Effective phase length: zero base reads as one, drift saturates high and floors at one.
    function automatic logic [CNT_W-1:0] phase_len(
        input logic [CNT_W-1:0] base,
        input logic             drifted,
        input logic [DRF_W-1:0] step,
        input logic             shorten
    );
        logic [CNT_W-1:0] base_nz;
        logic [SUM_W-1:0] base_w;
        logic [SUM_W-1:0] step_w;
        logic [SUM_W-1:0] sum_w;
        logic [CNT_W-1:0] result;
        base_nz = (base == '0) ? CNT_ONE : base;
        base_w  = SUM_W'(base_nz);
        step_w  = SUM_W'(step);
        sum_w   = base_w + step_w;
        result  = base_nz;
        if (drifted) begin
            if (!shorten) begin
                result = (sum_w > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum_w);
            end else begin
                result = (step_w >= base_w) ? CNT_ONE : CNT_W'(base_w - step_w);
            end
        end
        return result;
    endfunction

    assign inject_enabled = (bus.drift_interval_i != '0) && (bus.drift_target_i != 2'b00);
    assign interval_m1    = bus.drift_interval_i - CNT_ONE;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_cnt_q <= '0;
            edge_cnt_q  <= '0;
            clk_q       <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            any_q       <= 1'b0;
            inj_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            clk_q       <= clk_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            any_q       <= any_d;
            inj_q       <= inj_d;
        end
    end

    // Next-state: phase sequencing, per-phase sampling of periods and drift decision.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        clk_d       = clk_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        any_d       = 1'b0;
        inj_d       = 1'b0;
        start_phase = 1'b0;
        start_high  = 1'b0;
        eligible    = 1'b0;
        drift_now   = 1'b0;
        eff_len     = CNT_ONE;

        unique case (state_q)
            ST_IDLE: begin
                clk_d = 1'b0;
                if (bus.gen_en_i) begin
                    start_phase = 1'b1;
                    start_high  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_cnt_q == '0) begin
                    start_phase = 1'b1;
                    start_high  = 1'b0;
                end else begin
                    phase_cnt_d = phase_cnt_q - CNT_ONE;
                end
            end
            ST_LOW: begin
                if (phase_cnt_q == '0) begin
                    if (bus.gen_en_i) begin
                        start_phase = 1'b1;
                        start_high  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        clk_d   = 1'b0;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                clk_d   = 1'b0;
            end
        endcase

        if (start_phase) begin
            eligible = start_high ? bus.drift_target_i[0] : bus.drift_target_i[1];
            if (inject_enabled && eligible) begin
                if (edge_cnt_q == interval_m1) begin
                    drift_now  = 1'b1;
                    edge_cnt_d = '0;
                end else begin
                    edge_cnt_d = edge_cnt_q + CNT_ONE;
                end
            end
            eff_len     = phase_len(start_high ? bus.high_period_i : bus.low_period_i,
                                    drift_now, bus.drift_step_i, bus.drift_dir_i);
            state_d     = start_high ? ST_HIGH : ST_LOW;
            phase_cnt_d = eff_len - CNT_ONE;
            clk_d       = start_high;
            rise_d      = start_high;
            fall_d      = !start_high;
            any_d       = 1'b1;
            inj_d       = drift_now;
        end

        if (!inject_enabled) begin
            edge_cnt_d = '0;
        end

        // Synchronous clear behaves like reset and overrides everything above.
        if (bus.clear_state_i) begin
            state_d     = ST_IDLE;
            phase_cnt_d = '0;
            edge_cnt_d  = '0;
            clk_d       = 1'b0;
            rise_d      = 1'b0;
            fall_d      = 1'b0;
            any_d       = 1'b0;
            inj_d       = 1'b0;
        end
    end

    assign bus.clk_o            = clk_q;
    assign bus.rising_edge_o    = rise_q;
    assign bus.falling_edge_o   = fall_q;
    assign bus.any_valid_edge_o = any_q;
    assign bus.drift_injected_o = inj_q;

endmodule

// File: tb/tb_drift_injection_clock_generator.sv
// Directed bench for the drift-injection clock generator: per-cycle output traces
// are packed into vectors (sample 0 in the MSB) and compared with hand-derived patterns.
module tb_drift_injection_clock_generator;

    logic clk;
    logic rst_n;
    common_p::clk_dom_s sys_dom;

    int checks = 0;
    int errors = 0;

    always_comb begin
        sys_dom.clk   = clk;
        sys_dom.rst_n = rst_n;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    drift_injection_clock_generator_if #(.COUNTER_WIDTH(16), .DRIFT_WIDTH(8)) bus16 ();
    drift_injection_clock_generator_if #(.COUNTER_WIDTH(4),  .DRIFT_WIDTH(8)) bus4 ();

    drift_injection_clock_generator #(.COUNTER_WIDTH(16), .DRIFT_WIDTH(8)) dut (
        .sys_dom_i (sys_dom),
        .bus       (bus16)
    );

    drift_injection_clock_generator #(.COUNTER_WIDTH(4), .DRIFT_WIDTH(8)) dut_w4 (
        .sys_dom_i (sys_dom),
        .bus       (bus4)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Record n cycles of the selected DUT's outputs; optionally drop gen_en after sample drop_at.
    task automatic capture(input bit narrow, input int n, input int drop_at,
                           output logic [31:0] clkv, output logic [31:0] risev,
                           output logic [31:0] fallv, output logic [31:0] anyv,
                           output logic [31:0] injv);
        clkv = '0; risev = '0; fallv = '0; anyv = '0; injv = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (narrow) begin
                clkv  = {clkv[30:0],  bus4.clk_o};
                risev = {risev[30:0], bus4.rising_edge_o};
                fallv = {fallv[30:0], bus4.falling_edge_o};
                anyv  = {anyv[30:0],  bus4.any_valid_edge_o};
                injv  = {injv[30:0],  bus4.drift_injected_o};
            end else begin
                clkv  = {clkv[30:0],  bus16.clk_o};
                risev = {risev[30:0], bus16.rising_edge_o};
                fallv = {fallv[30:0], bus16.falling_edge_o};
                anyv  = {anyv[30:0],  bus16.any_valid_edge_o};
                injv  = {injv[30:0],  bus16.drift_injected_o};
            end
            if (i == drop_at) begin
                bus16.gen_en_i = 1'b0;
                bus4.gen_en_i  = 1'b0;
            end
        end
    endtask

    // One-cycle synchronous clear of both DUTs with generation disabled.
    task automatic clear_all();
        @(negedge clk);
        bus16.gen_en_i      = 1'b0;
        bus4.gen_en_i       = 1'b0;
        bus16.clear_state_i = 1'b1;
        bus4.clear_state_i  = 1'b1;
        @(negedge clk);
        bus16.clear_state_i = 1'b0;
        bus4.clear_state_i  = 1'b0;
    endtask

    task automatic setup16(input logic [15:0] h, input logic [15:0] l, input logic [7:0] step,
                           input logic dir, input logic [15:0] interval, input logic [1:0] target);
        bus16.high_period_i    = h;
        bus16.low_period_i     = l;
        bus16.drift_step_i     = step;
        bus16.drift_dir_i      = dir;
        bus16.drift_interval_i = interval;
        bus16.drift_target_i   = target;
    endtask

    logic [31:0] cv, rv, fv, av, iv;

    initial begin
        rst_n = 1'b0;
        bus16.gen_en_i = 1'b0; bus16.clear_state_i = 1'b0;
        bus4.gen_en_i  = 1'b0; bus4.clear_state_i  = 1'b0;
        setup16(16'd1, 16'd1, 8'd0, 1'b0, 16'd0, 2'b00);
        bus4.high_period_i = 4'd1; bus4.low_period_i = 4'd1; bus4.drift_step_i = 8'd0;
        bus4.drift_dir_i = 1'b0; bus4.drift_interval_i = 4'd0; bus4.drift_target_i = 2'b00;

        repeat (3) @(negedge clk);
        check("reset_clk",  32'(bus16.clk_o), 32'd0);
        check("reset_edge", 32'({bus16.rising_edge_o, bus16.falling_edge_o, bus16.any_valid_edge_o}), 32'd0);
        check("reset_inj",  32'(bus16.drift_injected_o), 32'd0);
        rst_n = 1'b1;

        // H=3 L=2, no drift: 11100 repeating, rise every 5.
        @(negedge clk);
        setup16(16'd3, 16'd2, 8'd0, 1'b0, 16'd0, 2'b01);
        bus16.gen_en_i = 1'b1;
        capture(1'b0, 15, -1, cv, rv, fv, av, iv);
        check("t1_clk",  cv, 32'b111001110011100);
        check("t1_rise", rv, 32'b100001000010000);
        check("t1_fall", fv, 32'b000100001000010);
        check("t1_any",  av, 32'b100101001010010);
        check("t1_inj",  iv, 32'd0);
        clear_all();

        // H=4 L=4, +2 on every 2nd high phase.
        setup16(16'd4, 16'd4, 8'd2, 1'b0, 16'd2, 2'b01);
        bus16.gen_en_i = 1'b1;
        capture(1'b0, 32, -1, cv, rv, fv, av, iv);
        check("t2_clk",  cv, 32'hF0FC3C3F);
        check("t2_rise", rv, 32'h80802020);
        check("t2_inj",  iv, 32'h00800020);
        clear_all();

        // H=2 L=2, -5 on every phase: floors to 1, toggles each cycle.
        setup16(16'd2, 16'd2, 8'd5, 1'b1, 16'd1, 2'b11);
        bus16.gen_en_i = 1'b1;
        capture(1'b0, 16, -1, cv, rv, fv, av, iv);
        check("t3_clk", cv, 32'h0000AAAA);
        check("t3_any", av, 32'h0000FFFF);
        check("t3_inj", iv, 32'h0000FFFF);
        clear_all();

        // 4-bit counters: H=14 +3 saturates at 15, L=1.
        bus4.high_period_i = 4'd14; bus4.low_period_i = 4'd1; bus4.drift_step_i = 8'd3;
        bus4.drift_dir_i = 1'b0; bus4.drift_interval_i = 4'd1; bus4.drift_target_i = 2'b01;
        bus4.gen_en_i = 1'b1;
        capture(1'b1, 32, -1, cv, rv, fv, av, iv);
        check("t4_clk", cv, 32'hFFFEFFFE);
        check("t4_inj", iv, 32'h80008000);
        clear_all();

        // H=5 L=3, enable dropped in the 2nd high cycle: both phases finish, then idle.
        setup16(16'd5, 16'd3, 8'd0, 1'b0, 16'd0, 2'b00);
        bus16.gen_en_i = 1'b1;
        capture(1'b0, 16, 0, cv, rv, fv, av, iv);
        check("t5_clk",  cv, 32'h0000F800);
        check("t5_rise", rv, 32'h00008000);
        check("t5_fall", fv, 32'h00000400);
        clear_all();

        // Clear mid-high: no falling pulse, restart with edge count back at zero.
        setup16(16'd3, 16'd1, 8'd1, 1'b0, 16'd2, 2'b01);
        bus16.gen_en_i = 1'b1;
        repeat (2) @(negedge clk);
        bus16.clear_state_i = 1'b1;
        @(negedge clk);
        check("t6_clr_clk",  32'(bus16.clk_o), 32'd0);
        check("t6_clr_edge", 32'({bus16.rising_edge_o, bus16.falling_edge_o, bus16.any_valid_edge_o}), 32'd0);
        bus16.clear_state_i = 1'b0;
        capture(1'b0, 8, -1, cv, rv, fv, av, iv);
        check("t6_clk", cv, 32'h000000EF);
        check("t6_inj", iv, 32'h00000008);
        clear_all();

        // Async reset mid-high: output drops without waiting for a clock edge.
        setup16(16'd6, 16'd2, 8'd0, 1'b0, 16'd0, 2'b00);
        bus16.gen_en_i = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_clk", 32'(bus16.clk_o), 32'd0);
        @(negedge clk);
        check("t7_rst_edge", 32'({bus16.rising_edge_o, bus16.falling_edge_o}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t7_restart_clk",  32'(bus16.clk_o), 32'd1);
        check("t7_restart_rise", 32'(bus16.rising_edge_o), 32'd1);
        clear_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
